sobel_edge_engine: RTL and testbench
====================================

# sobel_edge_engine

Parameterised 3x3 edge-detection stage for the camera pipeline, sitting between the grayscale/Bayer-combine stage and the VGA output formatter. It accepts one grayscale pixel per valid cycle and builds a 3x3 window from two internal line delays. Per frame it computes the Sobel X, Sobel Y, combined |Gx|+|Gy| or pass-through result, with optional binary thresholding. It emits exactly one output sample per accepted input sample, so downstream sync counting is unaffected.

## Interface
- DATA_W, 12, pixel width in and out
- IMG_W, 640, valid pixels per line (line-delay depth)
- OUT_SHIFT, 2, right shift applied to the kernel result before saturation

- iCLK  in  1  clock
- iRST  in  1  asynchronous, active-high reset
- iDATA  in  DATA_W  grayscale pixel
- iDVAL  in  1  pixel valid; the window advances only when this is high
- iSOF  in  1  start of frame; qualified by iDVAL and marks pixel (0,0)
- iMODE  in  2  0=|Gx|, 1=|Gy|, 2=|Gx|+|Gy|, 3=pass-through center pixel
- iBIN_EN  in  1  binary output enable
- iTHRESH  in  DATA_W  binary threshold
- oDATA  out  DATA_W  result sample
- oDVAL  out  1  result valid

## Operation
- Column counter 0..IMG_W-1 and row flag counter 0..2 (saturating) advance on each iDVAL.
  - Column wrap increments the row counter.
  - iDVAL&iSOF forces the current pixel to col 0, row 0.
  - iSOF without iDVAL is ignored.
- Mode and binary settings: iMODE, iBIN_EN and iTHRESH are latched on iDVAL&iSOF and held for the whole frame. Mid-frame changes have no effect.
- Window:
  - Two chained line_delay instances (depth IMG_W, enabled by iDVAL) provide rows r-1 and r-2.
  - A 3-tap shift register per row provides columns c, c-1, c-2.
  - The window center is pixel (r-1, c-1).
- Arithmetic:
  - Gx = right column minus left column, weights 1,2,1. Gy = bottom row minus top row, weights 1,2,1.
  - Gx and Gy are signed DATA_W+3 bits.
  - Magnitudes are unsigned DATA_W+3 bits. The sum in mode 2 is DATA_W+4 bits.
  - The result is shifted right by OUT_SHIFT, then saturated to 2^DATA_W-1.
  - Mode 3 outputs the center pixel unshifted.
- Border: if the current input has r<2 or c<2, the output data is 0 and the sample is still emitted with oDVAL=1. The line buffers are not cleared at SOF; the border masking covers stale contents.
- Binary: when latched iBIN_EN=1, output is 2^DATA_W-1 if result >= iTHRESH, else 0. Border samples remain 0.
- Reset:
  - oDATA=0, oDVAL=0, counters=0, pipeline valids=0, latched mode=0, binary enable=0.
  - Line-delay contents are don't-care.
  - The post-reset state is equivalent to SOF pending at (0,0).
  - Reset mid-frame aborts the frame, and oDVAL drops asynchronously.

## Timing
- Fixed latency of 3 iCLK cycles:
  - Stage 1 registers the window.
  - Stage 2 registers Gx and Gy.
  - Stage 3 registers abs, combine, shift, saturate and threshold into oDATA.
- oDVAL equals iDVAL delayed 3 cycles. The mask flag and latched mode travel with the valid.
- Gaps in iDVAL produce matching gaps in oDVAL and do not alter the data.
- Back-to-back frames: an SOF pixel may directly follow the last pixel of the previous frame with no idle cycle.
- A simultaneous iSOF and column wrap resolves in favour of SOF.

## Structure
- Shared package sobel_pkg holds:
  - the mode enum (MODE_GX, MODE_GY, MODE_SUM, MODE_PASS);
  - localparam helpers for the widths (DATA_W+3 and DATA_W+4).
- One sub-module, line_delay, with parameters DEPTH and WIDTH. It is an enable-gated delay of DEPTH samples, instantiated twice.

## Test plan
- Reset: hold iRST with iDVAL toggling -> oDVAL=0 and oDATA=0 throughout, and for 3 cycles after release.
- Flat frame, IMG_W=8, 6 rows, all pixels 100, mode 2 -> 48 outputs, all 0, each exactly 3 cycles after its input.
- Vertical step, IMG_W=8, cols 0-3=0 and cols 4-7=1000, mode 0, OUT_SHIFT=2 -> centers col 3 and col 4 give 1000 for rows ≥1, all others 0. Mode 1 on the same frame -> all 0.
- Saturation, OUT_SHIFT=0, DATA_W=12, horizontal step 0/4095, mode 2 -> edge samples = 4095 (16380 clipped).
- Binary and latching:
  - iBIN_EN=1, iTHRESH=500, step of 1000 -> edge samples 4095, others 0.
  - Toggling iMODE mid-frame -> no change until the next iSOF.
- Gaps and reset:
  - Random iDVAL gaps -> output data sequence identical to the gapless run.
  - iRST pulse mid-frame -> oDVAL=0 immediately.
  - The following frame then produces correct output.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and width helpers for the Sobel edge engine.
package sobel_pkg;

    typedef enum logic [1:0] {
        MODE_GX   = 2'd0,
        MODE_GY   = 2'd1,
        MODE_SUM  = 2'd2,
        MODE_PASS = 2'd3
    } mode_e;

    // Signed gradient width and unsigned |Gx|+|Gy| width for a given pixel width.
    function automatic int grad_width(input int data_w);
        return data_w + 3;
    endfunction

    function automatic int sum_width(input int data_w);
        return data_w + 4;
    endfunction

endpackage

// File: rtl/line_delay.sv
// Enable-gated delay line of DEPTH samples; storage is not reset.
module line_delay #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_ptr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_ptr <= '0;
        else if (i_en)
            r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_en)
            r_mem[r_ptr] <= i_data;
    end

    // Read-before-write: the slot about to be overwritten holds the sample from DEPTH enables ago.
    assign o_data = r_mem[r_ptr];

endmodule

// File: rtl/sobel_edge_engine.sv
// 3x3 Sobel edge stage: one output sample per accepted input, fixed 3-cycle latency.
module sobel_edge_engine
    import sobel_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int IMG_W     = 640,
    parameter int OUT_SHIFT = 2
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iDVAL,
    input  logic              iSOF,
    input  logic [1:0]        iMODE,
    input  logic              iBIN_EN,
    input  logic [DATA_W-1:0] iTHRESH,
    output logic [DATA_W-1:0] oDATA,
    output logic              oDVAL
);
    localparam int GW = grad_width(DATA_W);
    localparam int SW = sum_width(DATA_W);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [DATA_W-1:0] PIX_MAX = '1;

    logic [CW-1:0]     r_col;
    logic [1:0]        r_row;
    mode_e             r_mode;
    logic              r_bin;
    logic [DATA_W-1:0] r_thresh;

    logic              w_sof;
    logic [CW-1:0]     w_col_cur;
    logic [1:0]        w_row_cur;
    logic              w_border;
    logic [DATA_W-1:0] w_ld1, w_ld2;

    assign w_sof     = iDVAL & iSOF;
    assign w_col_cur = w_sof ? '0 : r_col;
    assign w_row_cur = w_sof ? 2'd0 : r_row;
    assign w_border  = (w_row_cur < 2'd2) || (w_col_cur < CW'(2));

    line_delay #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_ld1 (
        .i_clk(iCLK), .i_rst(iRST), .i_en(iDVAL), .i_data(iDATA), .o_data(w_ld1)
    );
    line_delay #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_ld2 (
        .i_clk(iCLK), .i_rst(iRST), .i_en(iDVAL), .i_data(w_ld1), .o_data(w_ld2)
    );

    // Post-reset counters sit at (0,0), so a frame may start without an explicit SOF.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_col    <= '0;
            r_row    <= '0;
            r_mode   <= MODE_GX;
            r_bin    <= 1'b0;
            r_thresh <= '0;
        end else if (iDVAL) begin
            if (w_col_cur == CW'(IMG_W - 1)) begin
                r_col <= '0;
                r_row <= (w_row_cur == 2'd2) ? 2'd2 : w_row_cur + 2'd1;
            end else begin
                r_col <= w_col_cur + 1'b1;
                r_row <= w_row_cur;
            end
            if (iSOF) begin
                r_mode   <= mode_e'(iMODE);
                r_bin    <= iBIN_EN;
                r_thresh <= iTHRESH;
            end
        end
    end

    // Stage 1: window, index 0 = column c, rows b/m/t = r, r-1, r-2.
    logic [DATA_W-1:0] r_b [3];
    logic [DATA_W-1:0] r_m [3];
    logic [DATA_W-1:0] r_t [3];
    logic              r_v1, r_mask1, r_bin1;
    mode_e             r_mode1;
    logic [DATA_W-1:0] r_th1;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            for (int i = 0; i < 3; i++) begin
                r_b[i] <= '0;
                r_m[i] <= '0;
                r_t[i] <= '0;
            end
            r_v1    <= 1'b0;
            r_mask1 <= 1'b1;
            r_mode1 <= MODE_GX;
            r_bin1  <= 1'b0;
            r_th1   <= '0;
        end else begin
            r_v1 <= iDVAL;
            if (iDVAL) begin
                r_b[0] <= iDATA;
                r_m[0] <= w_ld1;
                r_t[0] <= w_ld2;
                for (int i = 1; i < 3; i++) begin
                    r_b[i] <= r_b[i-1];
                    r_m[i] <= r_m[i-1];
                    r_t[i] <= r_t[i-1];
                end
                r_mask1 <= w_border;
                r_mode1 <= w_sof ? mode_e'(iMODE) : r_mode;
                r_bin1  <= w_sof ? iBIN_EN : r_bin;
                r_th1   <= w_sof ? iTHRESH : r_thresh;
            end
        end
    end

    function automatic logic signed [GW-1:0] wsum(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic [DATA_W-1:0] c);
        return $signed({3'b000, a}) + ($signed({3'b000, b}) <<< 1) + $signed({3'b000, c});
    endfunction

    logic signed [GW-1:0] w_gx, w_gy;
    assign w_gx = wsum(r_t[0], r_m[0], r_b[0]) - wsum(r_t[2], r_m[2], r_b[2]);
    assign w_gy = wsum(r_b[2], r_b[1], r_b[0]) - wsum(r_t[2], r_t[1], r_t[0]);

    // Stage 2: gradients plus the side-band that travels with the sample.
    logic signed [GW-1:0] r_gx, r_gy;
    logic [DATA_W-1:0]    r_center2, r_th2;
    logic                 r_v2, r_mask2, r_bin2;
    mode_e                r_mode2;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_gx      <= '0;
            r_gy      <= '0;
            r_center2 <= '0;
            r_th2     <= '0;
            r_v2      <= 1'b0;
            r_mask2   <= 1'b1;
            r_bin2    <= 1'b0;
            r_mode2   <= MODE_GX;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_gx      <= w_gx;
                r_gy      <= w_gy;
                r_center2 <= r_m[1];
                r_th2     <= r_th1;
                r_mask2   <= r_mask1;
                r_bin2    <= r_bin1;
                r_mode2   <= r_mode1;
            end
        end
    end

    logic [GW-1:0]     w_ax, w_ay;
    logic [SW-1:0]     w_sel;
    logic [DATA_W-1:0] w_res, w_out;

    assign w_ax = r_gx[GW-1] ? GW'(-r_gx) : GW'(r_gx);
    assign w_ay = r_gy[GW-1] ? GW'(-r_gy) : GW'(r_gy);

    always_comb begin
        w_sel = '0;
        case (r_mode2)
            MODE_GX:   w_sel = SW'(w_ax) >> OUT_SHIFT;
            MODE_GY:   w_sel = SW'(w_ay) >> OUT_SHIFT;
            MODE_SUM:  w_sel = (SW'(w_ax) + SW'(w_ay)) >> OUT_SHIFT;
            MODE_PASS: w_sel = SW'(r_center2);
            default:   w_sel = '0;
        endcase
    end

    assign w_res = (w_sel > SW'(PIX_MAX)) ? PIX_MAX : w_sel[DATA_W-1:0];
    assign w_out = r_mask2 ? '0 :
                   r_bin2  ? ((w_res >= r_th2) ? PIX_MAX : '0) : w_res;

    // Stage 3: output register.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oDATA <= '0;
            oDVAL <= 1'b0;
        end else begin
            oDVAL <= r_v2;
            if (r_v2)
                oDATA <= w_out;
        end
    end

endmodule

// File: tb/tb_sobel_edge_engine.sv
// Directed + randomized bench for sobel_edge_engine (IMG_W=8), two instances with OUT_SHIFT 2 and 0.
module tb_sobel_edge_engine;
    localparam int DW   = 12;
    localparam int IW   = 8;
    localparam int MAXV = 4095;

    logic          iCLK, iRST, iDVAL, iSOF, iBIN_EN;
    logic [DW-1:0] iDATA, iTHRESH;
    logic [1:0]    iMODE;
    logic [DW-1:0] oDATA_a, oDATA_b;
    logic          oDVAL_a, oDVAL_b;

    sobel_edge_engine #(.DATA_W(DW), .IMG_W(IW), .OUT_SHIFT(2)) u_dut_s2 (
        .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL), .iSOF(iSOF),
        .iMODE(iMODE), .iBIN_EN(iBIN_EN), .iTHRESH(iTHRESH),
        .oDATA(oDATA_a), .oDVAL(oDVAL_a)
    );
    sobel_edge_engine #(.DATA_W(DW), .IMG_W(IW), .OUT_SHIFT(0)) u_dut_s0 (
        .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL), .iSOF(iSOF),
        .iMODE(iMODE), .iBIN_EN(iBIN_EN), .iTHRESH(iTHRESH),
        .oDATA(oDATA_b), .oDVAL(oDVAL_b)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;

    // Reference model: last 4 frame rows, frame position, per-frame settings.
    int pix [4][IW];
    int m_idx, m_mode, m_bin, m_th;
    bit ev [3];
    int ea [3];
    int eb [3];

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic int expect_val(input int r, input int c, input int shift,
                                      input int mode, input int bin, input int th);
        int p [3][3];
        int gx, gy, res;
        if (r < 2 || c < 2) return 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = pix[(r - 2 + i) % 4][c - 2 + j];
        gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
        gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
        case (mode)
            0:       res = iabs(gx) >> shift;
            1:       res = iabs(gy) >> shift;
            2:       res = (iabs(gx) + iabs(gy)) >> shift;
            default: res = p[1][1];
        endcase
        if (res > MAXV) res = MAXV;
        if (bin != 0) res = (res >= th) ? MAXV : 0;
        return res;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit dv, input bit sof, input int d,
                        input int mode, input int bin, input int th);
        int r, c;
        @(negedge iCLK);
        check("dval_s2", {31'd0, oDVAL_a}, {31'd0, ev[2]});
        check("dval_s0", {31'd0, oDVAL_b}, {31'd0, ev[2]});
        if (ev[2]) begin
            check("data_s2", {20'd0, oDATA_a}, ea[2]);
            check("data_s0", {20'd0, oDATA_b}, eb[2]);
        end
        for (int k = 2; k > 0; k--) begin
            ev[k] = ev[k-1];
            ea[k] = ea[k-1];
            eb[k] = eb[k-1];
        end
        iRST    = 1'b0;
        iDVAL   = dv;
        iSOF    = sof;
        iDATA   = DW'(d);
        iMODE   = 2'(mode);
        iBIN_EN = bin[0];
        iTHRESH = DW'(th);
        ev[0] = dv;
        ea[0] = 0;
        eb[0] = 0;
        if (dv) begin
            if (sof) begin
                m_idx  = 0;
                m_mode = mode;
                m_bin  = bin;
                m_th   = th;
            end
            r = m_idx / IW;
            c = m_idx % IW;
            pix[r % 4][c] = d;
            ea[0] = expect_val(r, c, 2, m_mode, m_bin, m_th);
            eb[0] = expect_val(r, c, 0, m_mode, m_bin, m_th);
            m_idx++;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'($urandom_range(1)), $urandom_range(MAXV), $urandom_range(3),
             $urandom_range(1), $urandom_range(MAXV));
    endtask

    task automatic rst_step();
        @(negedge iCLK);
        iRST  = 1'b1;
        iDVAL = 1'($urandom_range(1));
        iSOF  = 1'($urandom_range(1));
        iDATA = DW'($urandom_range(MAXV));
        #1;
        check("rst_dval_s2", {31'd0, oDVAL_a}, 0);
        check("rst_dval_s0", {31'd0, oDVAL_b}, 0);
        check("rst_data_s2", {20'd0, oDATA_a}, 0);
        check("rst_data_s0", {20'd0, oDATA_b}, 0);
        for (int k = 0; k < 3; k++) begin
            ev[k] = 1'b0;
            ea[k] = 0;
            eb[k] = 0;
        end
        m_idx  = 0;
        m_mode = 0;
        m_bin  = 0;
        m_th   = 0;
    endtask

    function automatic int pat(input int kind, input int r, input int c);
        case (kind)
            0:       return 100;
            1:       return (c >= 4) ? 1000 : 0;
            2:       return (r >= 3) ? MAXV : 0;
            default: return $urandom_range(MAXV);
        endcase
    endfunction

    task automatic send_frame(input int kind, input int rows, input int mode, input int bin,
                              input int th, input int gap_pct, input bit toggle,
                              input bit with_sof, input int abort_at);
        bit first;
        for (int i = 0; i < rows * IW; i++) begin
            if (i == abort_at) begin
                rst_step();
                return;
            end
            for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++)
                idle();
            first = (i == 0);
            if (first || !toggle)
                step(1'b1, first && with_sof, pat(kind, i / IW, i % IW), mode, bin, th);
            else
                step(1'b1, 1'b0, pat(kind, i / IW, i % IW), $urandom_range(3),
                     $urandom_range(1), $urandom_range(MAXV));
        end
    endtask

    initial begin
        iRST = 1'b1; iDVAL = 1'b0; iSOF = 1'b0; iDATA = '0;
        iMODE = '0; iBIN_EN = 1'b0; iTHRESH = '0;
        m_idx = 0; m_mode = 0; m_bin = 0; m_th = 0;
        for (int k = 0; k < 3; k++) begin
            ev[k] = 1'b0; ea[k] = 0; eb[k] = 0;
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < IW; j++)
                pix[i][j] = 0;

        for (int i = 0; i < 6; i++) rst_step();
        for (int i = 0; i < 3; i++) idle();

        send_frame(0, 6, 2, 0, 0,   0, 1'b0, 1'b1, -1);   // flat
        send_frame(1, 6, 0, 0, 0,   0, 1'b0, 1'b1, -1);   // vertical step, |Gx|
        send_frame(1, 6, 1, 0, 0,   0, 1'b0, 1'b1, -1);   // vertical step, |Gy|
        send_frame(2, 6, 2, 0, 0,   0, 1'b0, 1'b1, -1);   // horizontal 0/4095, saturation
        send_frame(1, 6, 2, 1, 500, 0, 1'b0, 1'b1, -1);   // binary threshold
        send_frame(1, 6, 3, 0, 0,   0, 1'b1, 1'b1, -1);   // pass-through, settings toggled mid-frame
        send_frame(3, 6, 2, 0, 0,  30, 1'b1, 1'b1, -1);   // random data with gaps
        for (int f = 0; f < 4; f++)
            send_frame(3, 5, $urandom_range(3), $urandom_range(1), $urandom_range(MAXV),
                       $urandom_range(40), 1'b1, 1'b1, -1);
        send_frame(1, 6, 0, 0, 0, 10, 1'b0, 1'b1, 29);    // aborted by reset
        send_frame(1, 6, 2, 0, 0, 10, 1'b0, 1'b0, -1);    // no SOF: reset defaults apply
        send_frame(3, 6, 2, 1, 300, 20, 1'b0, 1'b1, -1);
        for (int i = 0; i < 5; i++) idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
